// File: rtl/traffic_analyzer_stats_axil_regs_if.sv
// AXI4-Lite slave bus bundle for the traffic analyzer statistics register block.
// The master modport drives requests; the slave modport returns ready/response.
interface traffic_analyzer_stats_axil_regs_if #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/traffic_analyzer_stats_axil_regs.sv
// AXI4-Lite register file for traffic analyzer cores: counter snapshots, clear pulses, frame buffer.
// Define TRAFFIC_ANALYZER_STATS_SLVERR_EN to return SLVERR (data 0) on bad accesses.
module traffic_analyzer_stats_axil_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH        = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH        = 12,
   parameter logic [31:0] C_BASE_ADDRESS            = 32'h0,
   parameter int unsigned C_NUM_COUNTERS            = 16,
   parameter int unsigned C_COUNTER_WIDTH           = 64,
   parameter int unsigned C_FRAME_BUF_ADDRESS_WIDTH = 9
) (
   input  logic                                        S_AXI_ACLK,
   input  logic                                        S_AXI_ARESETN,
   traffic_analyzer_stats_axil_regs_if.slave           s_axi,
   input  logic [31:0]                                 i_id_reg,
   input  logic [31:0]                                 i_version_reg,
   output logic [31:0]                                 o_control_reg,
   input  logic [C_NUM_COUNTERS*C_COUNTER_WIDTH-1:0]   i_counters_in,
   output logic [C_NUM_COUNTERS-1:0]                   o_counter_clear,
   input  logic [31:0]                                 i_frame_size_reg,
   output logic [C_FRAME_BUF_ADDRESS_WIDTH-1:0]        o_frame_buf_address,
   input  logic [31:0]                                 i_frame_buf_data
);

   localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned FBW = C_FRAME_BUF_ADDRESS_WIDTH;
   localparam logic [AW-1:0] BaseAddr  = C_BASE_ADDRESS[AW-1:0];
   localparam logic [AW-1:0] AddrId    = AW'(32'h000);
   localparam logic [AW-1:0] AddrVer   = AW'(32'h004);
   localparam logic [AW-1:0] AddrCtrl  = AW'(32'h008);
   localparam logic [AW-1:0] AddrSnap  = AW'(32'h00C);
   localparam logic [AW-1:0] AddrClear = AW'(32'h010);
   localparam logic [AW-1:0] AddrFSize = AW'(32'h014);
   localparam logic [AW-1:0] AddrFBuf  = AW'(32'h018);
   localparam logic [1:0]    RespOkay   = 2'b00;
   localparam logic [1:0]    RespSlvErr = 2'b10;
`ifdef TRAFFIC_ANALYZER_STATS_SLVERR_EN
   localparam bit SlvErrEn = 1'b1;
`else
   localparam bit SlvErrEn = 1'b0;
`endif

   typedef enum logic [1:0] {RIdle, RWait, RData} rd_state_e;

   rd_state_e                    r_rd_state, w_rd_state_nxt;
   logic [31:0]                  r_control;
   logic [C_NUM_COUNTERS-1:0]    r_clear;
   logic [31:0]                  r_snap_cnt;
   logic [63:0]                  r_shadow [C_NUM_COUNTERS];
   logic [63:0]                  w_live   [C_NUM_COUNTERS];
   logic                         r_bvalid;
   logic [1:0]                   r_bresp;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                   r_rresp;
   logic                         r_rd_fb;
   logic [FBW-1:0]               r_fb_addr;

   logic [AW-1:0]                w_woff, w_roff;
   logic [31:0]                  w_bmask;
   logic                         w_wr_accept, w_wr_ctrl, w_wr_snap, w_wr_clear, w_wr_err;
   logic                         w_arready, w_ar_hs;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
   logic                         w_rd_err, w_rd_fb, w_rd_fsize;

   assign w_woff      = s_axi.awaddr ^ BaseAddr;
   assign w_roff      = s_axi.araddr ^ BaseAddr;
   assign w_wr_accept = s_axi.awvalid & s_axi.wvalid & ~r_bvalid;
   assign w_ar_hs     = s_axi.arvalid & w_arready;

   always_comb begin
      for (int b = 0; b < 4; b++) w_bmask[8*b +: 8] = {8{s_axi.wstrb[b]}};
   end

   always_comb begin
      for (int i = 0; i < int'(C_NUM_COUNTERS); i++) begin
         w_live[i] = 64'(i_counters_in[i*C_COUNTER_WIDTH +: C_COUNTER_WIDTH]);
      end
   end

   // Write decode: the whole counter window is read-only.
   always_comb begin
      w_wr_ctrl  = 1'b0;
      w_wr_snap  = 1'b0;
      w_wr_clear = 1'b0;
      w_wr_err   = 1'b0;
      case (w_woff)
         AddrCtrl:  w_wr_ctrl  = 1'b1;
         AddrSnap:  w_wr_snap  = 1'b1;
         AddrClear: w_wr_clear = 1'b1;
         default:   w_wr_err   = 1'b1;
      endcase
   end

   always_comb begin
      w_rd_data  = '0;
      w_rd_err   = 1'b0;
      w_rd_fb    = 1'b0;
      w_rd_fsize = 1'b0;
      if (w_roff[AW-1:8] == (AW-8)'(1) && w_roff[1:0] == 2'b00) begin
         w_rd_err = 1'b1;
         for (int i = 0; i < int'(C_NUM_COUNTERS); i++) begin
            if (32'(w_roff[7:3]) == 32'(i)) begin
               w_rd_err  = 1'b0;
               w_rd_data = w_roff[2] ? r_shadow[i][31:0] : r_shadow[i][63:32];
            end
         end
      end else begin
         case (w_roff)
            AddrId:    w_rd_data = i_id_reg;
            AddrVer:   w_rd_data = i_version_reg;
            AddrCtrl:  w_rd_data = r_control;
            AddrSnap:  w_rd_data = r_snap_cnt;
            AddrClear: w_rd_data = '0;
            AddrFSize: begin
               w_rd_data  = i_frame_size_reg;
               w_rd_fsize = 1'b1;
            end
            AddrFBuf:  w_rd_fb  = 1'b1;
            default:   w_rd_err = 1'b1;
         endcase
      end
      if (w_rd_err) w_rd_data = SlvErrEn ? '0 : 32'hDEAD_BEEF;
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_bvalid   <= 1'b0;
         r_bresp    <= RespOkay;
         r_control  <= 32'h1;
         r_clear    <= '0;
         r_snap_cnt <= '0;
         for (int i = 0; i < int'(C_NUM_COUNTERS); i++) r_shadow[i] <= '0;
      end else begin
         r_clear <= '0;
         if (w_wr_accept) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (SlvErrEn && w_wr_err) ? RespSlvErr : RespOkay;
            if (w_wr_ctrl) r_control <= (r_control & ~w_bmask) | (s_axi.wdata & w_bmask);
            // All shadows load on the same edge so software sees one coherent sample.
            if (w_wr_snap && s_axi.wstrb[0] && s_axi.wdata[0]) begin
               for (int i = 0; i < int'(C_NUM_COUNTERS); i++) r_shadow[i] <= w_live[i];
               r_snap_cnt <= r_snap_cnt + 32'd1;
            end
            if (w_wr_clear) r_clear <= C_NUM_COUNTERS'(s_axi.wdata & w_bmask);
         end else if (r_bvalid && s_axi.bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) r_rd_state <= RIdle;
      else                r_rd_state <= w_rd_state_nxt;
   end

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      w_arready      = 1'b0;
      case (r_rd_state)
         RIdle: begin
            w_arready = 1'b1;
            if (s_axi.arvalid) w_rd_state_nxt = w_rd_fb ? RWait : RData;
         end
         RWait:   w_rd_state_nxt = RData;
         RData:   if (s_axi.rready) w_rd_state_nxt = RIdle;
         default: w_rd_state_nxt = RIdle;
      endcase
   end

   // Read data is captured at acceptance; frame RAM data one cycle later in RWait.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_rdata   <= '0;
         r_rresp   <= RespOkay;
         r_rd_fb   <= 1'b0;
         r_fb_addr <= '0;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_data;
         r_rresp <= (SlvErrEn && w_rd_err) ? RespSlvErr : RespOkay;
         r_rd_fb <= w_rd_fb;
         if (w_rd_fsize) r_fb_addr <= '0;
      end else if (r_rd_state == RWait) begin
         r_rdata <= i_frame_buf_data;
      end else if (r_rd_state == RData && s_axi.rready && r_rd_fb) begin
         r_fb_addr <= r_fb_addr + FBW'(1);
      end
   end

   assign s_axi.awready       = w_wr_accept;
   assign s_axi.wready        = w_wr_accept;
   assign s_axi.bvalid        = r_bvalid;
   assign s_axi.bresp         = r_bresp;
   assign s_axi.arready       = w_arready;
   assign s_axi.rvalid        = (r_rd_state == RData);
   assign s_axi.rdata         = r_rdata;
   assign s_axi.rresp         = r_rresp;
   assign o_control_reg       = r_control;
   assign o_counter_clear     = r_clear;
   assign o_frame_buf_address = r_fb_addr;

endmodule

// File: tb/tb_traffic_analyzer_stats_axil_regs.sv
// Directed bench for traffic_analyzer_stats_axil_regs: register map, snapshot, clear, frame buffer,
// unmapped accesses and asynchronous reset during a held write response.
module tb_traffic_analyzer_stats_axil_regs;
   localparam int unsigned N   = 16;
   localparam int unsigned CW  = 64;
   localparam int unsigned FBW = 9;
   localparam int unsigned AW  = 12;
`ifdef TRAFFIC_ANALYZER_STATS_SLVERR_EN
   localparam logic [31:0] BadData = 32'h0;
   localparam logic [1:0]  BadResp = 2'b10;
`else
   localparam logic [31:0] BadData = 32'hDEAD_BEEF;
   localparam logic [1:0]  BadResp = 2'b00;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       id_reg = 32'hA11C_0001;
   logic [31:0]       version_reg = 32'h0002_0003;
   logic [31:0]       fsize_reg = 32'd1500;
   logic [31:0]       control;
   logic [N*CW-1:0]   cnt_in = '0;
   logic [N-1:0]      clr;
   logic [FBW-1:0]    fb_addr;
   logic [31:0]       fb_data = '0;
   int                n_cmp = 0;
   int                n_err = 0;
   int                clr_cycles = 0;
   logic [N-1:0]      clr_seen = '0;

   always #5 clk = ~clk;

   traffic_analyzer_stats_axil_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) axi ();

   traffic_analyzer_stats_axil_regs dut (
      .S_AXI_ACLK          (clk),
      .S_AXI_ARESETN       (rst_n),
      .s_axi               (axi),
      .i_id_reg            (id_reg),
      .i_version_reg       (version_reg),
      .o_control_reg       (control),
      .i_counters_in       (cnt_in),
      .o_counter_clear     (clr),
      .i_frame_size_reg    (fsize_reg),
      .o_frame_buf_address (fb_addr),
      .i_frame_buf_data    (fb_data)
   );

   // Frame RAM model: word k holds F000_0000 | k, one cycle of read latency.
   always @(posedge clk) fb_data <= 32'hF000_0000 | 32'(fb_addr);

   always @(negedge clk) begin
      if (clr != '0) begin
         clr_cycles <= clr_cycles + 1;
         clr_seen   <= clr;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit hold_b, output logic [1:0] resp, output int blat);
      int n;
      axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
      #1;
      n = 0;
      while (!axi.awready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      blat = 1; n = 0;
      while (!axi.bvalid && n < 20) begin @(posedge clk); #1; blat++; n++; end
      resp = axi.bresp;
      if (!hold_b) begin
         axi.bready = 1'b1;
         @(posedge clk); #1;
         axi.bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] a, input int rdly, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
      int n;
      logic [31:0] d0;
      axi.araddr = a; axi.arvalid = 1'b1;
      #1;
      n = 0;
      while (!axi.arready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      lat = 1; n = 0;
      while (!axi.rvalid && n < 20) begin @(posedge clk); #1; lat++; n++; end
      d0 = axi.rdata;
      if (rdly > 0) begin
         repeat (rdly) begin @(posedge clk); #1; end
         check("rdata_hold", {31'b0, axi.rvalid, axi.rdata}, {31'b0, 1'b1, d0});
      end
      d = axi.rdata;
      resp = axi.rresp;
      axi.rready = 1'b1;
      @(posedge clk); #1;
      axi.rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
      axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_control", control, 32'h1);
      check("rst_clear", clr, 0);
      check("rst_fbaddr", fb_addr, 0);
      check("rst_bvalid", axi.bvalid, 0);
      check("rst_rvalid", axi.rvalid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      axi_read(12'h008, 0, d, r, lat);
      check("rd_control", d, 32'h1);
      check("rd_control_resp", r, 2'b00);
      check("rd_lat_reg", lat, 1);
      axi_read(12'h000, 2, d, r, lat);
      check("rd_id", d, 32'hA11C_0001);
      axi_read(12'h004, 0, d, r, lat);
      check("rd_version", d, 32'h0002_0003);
      axi_read(12'h00C, 0, d, r, lat);
      check("rd_snapcnt0", d, 0);

      // Byte-strobed control write: lanes 0 and 2 only.
      axi_write(12'h008, 32'hAABB_CCDD, 4'b0101, 1'b0, r, lat);
      check("wr_blat", lat, 1);
      check("wr_ctrl_resp", r, 2'b00);
      check("ctrl_strb", control, 32'h00BB_00DD);
      axi_read(12'h008, 0, d, r, lat);
      check("rd_ctrl_strb", d, 32'h00BB_00DD);

      cnt_in[0*CW +: CW]  = 64'h0000_0001_0000_0002;
      cnt_in[3*CW +: CW]  = 64'hCAFE_F00D_1234_5678;
      cnt_in[15*CW +: CW] = 64'hFFFF_FFFF_FFFF_FFFF;
      axi_write(12'h00C, 32'h1, 4'hF, 1'b0, r, lat);
      check("snap_blat", lat, 1);
      for (int i = 0; i < int'(N); i++) cnt_in[i*CW +: CW] = 64'h7777_7777_8888_8888;
      axi_read(12'h100, 0, d, r, lat);
      check("c0_hi", d, 32'h1);
      axi_read(12'h104, 0, d, r, lat);
      check("c0_lo", d, 32'h2);
      axi_read(12'h118, 0, d, r, lat);
      check("c3_hi", d, 32'hCAFE_F00D);
      axi_read(12'h11C, 0, d, r, lat);
      check("c3_lo", d, 32'h1234_5678);
      axi_read(12'h178, 0, d, r, lat);
      check("c15_hi", d, 32'hFFFF_FFFF);
      axi_read(12'h00C, 0, d, r, lat);
      check("snapcnt1", d, 32'h1);
      axi_write(12'h00C, 32'h0, 4'hF, 1'b0, r, lat);
      axi_read(12'h104, 0, d, r, lat);
      check("nosnap_lo", d, 32'h2);
      axi_read(12'h00C, 0, d, r, lat);
      check("snapcnt_hold", d, 32'h1);

      clr_cycles = 0;
      axi_write(12'h010, 32'h5, 4'hF, 1'b0, r, lat);
      repeat (3) @(posedge clk);
      #1;
      check("clr_cycles", clr_cycles, 1);
      check("clr_value", clr_seen, 16'h0005);
      check("clr_after", clr, 0);
      axi_read(12'h104, 0, d, r, lat);
      check("clr_shadow", d, 32'h2);
      axi_read(12'h010, 0, d, r, lat);
      check("rd_clear", d, 0);

      axi_read(12'h014, 0, d, r, lat);
      check("rd_fsize", d, 32'd1500);
      check("fbaddr_rst", fb_addr, 0);
      for (int k = 0; k < 3; k++) begin
         axi_read(12'h018, 2, d, r, lat);
         check("fb_data", d, 32'hF000_0000 | 32'(k));
         check("fb_lat", lat, 2);
      end
      check("fbaddr_end", fb_addr, 3);
      axi_read(12'h014, 0, d, r, lat);
      check("fbaddr_zero", fb_addr, 0);

      axi_read(12'h7F0, 0, d, r, lat);
      check("unmapped_data", d, BadData);
      check("unmapped_resp", r, BadResp);
      axi_read(12'h180, 0, d, r, lat);
      check("cidx16_data", d, BadData);
      axi_write(12'h000, 32'h1234, 4'hF, 1'b0, r, lat);
      check("wr_ro_resp", r, BadResp);
      axi_write(12'h7F0, 32'h1234, 4'hF, 1'b0, r, lat);
      check("wr_unmapped_resp", r, BadResp);
      check("ctrl_untouched", control, 32'h00BB_00DD);

      // Reset lands while the write response is still held.
      axi_write(12'h008, 32'h1234_5678, 4'hF, 1'b1, r, lat);
      check("held_bvalid", axi.bvalid, 1);
      check("held_ctrl", control, 32'h1234_5678);
      rst_n = 1'b0;
      #1;
      check("arst_bvalid", axi.bvalid, 0);
      check("arst_ctrl", control, 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      axi_read(12'h00C, 0, d, r, lat);
      check("arst_snapcnt", d, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
